// File: rtl/alu_seq_divider_pkg.sv
// Shared definitions for the ALU DIV path: FSM state encoding and result-stream slice index.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_seq_divider_pkg;

  // Divider FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // Position of the DIV slice in the ALU result stream. The control unit
  // and the one-hot result selector index the stream with the same value.
  localparam int ALU_DIV_SLICE = 3;

endpackage

// File: rtl/alu_seq_divider_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
//
// Ports:
//   rem, q   - current partial remainder and quotient/dividend shift register
//   dvs      - divisor magnitude (unsigned, nonzero)
//   rem_nxt  - partial remainder after this step
//   q_nxt    - quotient register after this step (new quotient bit in LSB)
module div_step #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] rem,
  input  logic [BITS-1:0] q,
  input  logic [BITS-1:0] dvs,
  output logic [BITS-1:0] rem_nxt,
  output logic [BITS-1:0] q_nxt
);

  logic [BITS:0]   shifted;
  logic [BITS-1:0] diff;
  logic            ge;

  always_comb begin
    // {rem,q} shifted left by one; the top bit of q moves into rem.
    shifted = {rem, q[BITS-1]};
    ge      = (shifted >= {1'b0, dvs});
    // When the trial is kept, the true difference is below dvs and so fits
    // in BITS bits; the modulo-2^BITS subtraction is exact in that case.
    diff    = shifted[BITS-1:0] - dvs;
    rem_nxt = ge ? diff : shifted[BITS-1:0];
    q_nxt   = {q[BITS-2:0], ge};
  end

endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle signed divider for the ALU DIV op, producing {remainder, quotient}.
// Latency: done pulses BITS+2 edges after the accept edge; 1 edge for divide-by-zero.
// Backpressure: start is only honoured in IDLE; starts while busy are dropped.
//
// Ports:
//   clk          - rising-edge clock
//   clr_n        - asynchronous active-low reset
//   start        - division request, sampled in IDLE
//   dividend     - signed numerator, captured on accepted start
//   divisor      - signed denominator, captured on accepted start
//   busy         - operation in progress
//   done         - one-cycle completion pulse; result valid from this cycle
//   div_by_zero  - flag of the last completed operation
//   result       - {remainder, quotient}, registered and held until next completion
module alu_seq_divider
  import alu_seq_divider_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [BITS-1:0]   dividend,
  input  logic [BITS-1:0]   divisor,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [2*BITS-1:0] result
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  div_state_t      state_q, state_d;
  logic            busy_d, done_d;
  logic [CW-1:0]   cnt_q;
  logic            last_step;

  logic [BITS-1:0] rem_q, quo_q, dvs_mag_q;
  logic [BITS-1:0] rem_step, quo_step;
  logic            sgn_dvd_q, sgn_dvs_q;

  logic [BITS-1:0] dvd_mag, dvs_mag;
  logic [BITS-1:0] quo_fix, rem_fix;
  logic            dvs_zero;

  // Magnitudes as unsigned BITS-bit values: -2^(BITS-1) negates to
  // 2^(BITS-1), which is exact when read as unsigned.
  assign dvd_mag  = dividend[BITS-1] ? -dividend : dividend;
  assign dvs_mag  = divisor[BITS-1]  ? -divisor  : divisor;
  assign dvs_zero = (divisor == '0);

  assign last_step = (cnt_q == CW'(BITS-1));

  // Sign correction: quotient negative when operand signs differ,
  // remainder follows the dividend's sign.
  assign quo_fix = (sgn_dvd_q ^ sgn_dvs_q) ? -quo_q : quo_q;
  assign rem_fix = sgn_dvd_q ? -rem_q : rem_q;

  div_step #(
    .BITS (BITS)
  ) u_step (
    .rem     (rem_q),
    .q       (quo_q),
    .dvs     (dvs_mag_q),
    .rem_nxt (rem_step),
    .q_nxt   (quo_step)
  );

  // Next-state and output decode. busy/done are registered from the
  // current state, so they trail the state by one edge.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = dvs_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        if (last_step) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        busy_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_mag_q   <= '0;
      sgn_dvd_q   <= 1'b0;
      sgn_dvs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sgn_dvd_q <= dividend[BITS-1];
            sgn_dvs_q <= divisor[BITS-1];
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            dvs_mag_q <= dvs_mag;
            cnt_q     <= '0;
            // Divide-by-zero skips the iteration; its result is final now.
            if (dvs_zero) begin
              result      <= {dividend, {BITS{1'b1}}};
              div_by_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: begin
          result      <= {rem_fix, quo_fix};
          div_by_zero <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider: vector table, random ops and handshake corner cases.
// Latency: checks done timing relative to the accept edge.
// Backpressure: checks that starts issued while busy are dropped.
module tb_alu_seq_divider;
  import alu_seq_divider_pkg::*;

  localparam int BITS = 32;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [63:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t sb[$];

  alu_seq_divider #(.BITS(BITS)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: signed 64-bit division truncating toward zero.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t   e;
    longint sa, sv, qq, rr;
    e.a = a;
    e.b = b;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      sa = {{32{a[31]}}, a};
      sv = {{32{b[31]}}, b};
      qq = sa / sv;
      rr = sa % sv;
      e.q  = qq[31:0];
      e.r  = rr[31:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Present a start for one cycle; operands are scrambled after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(output int n, output int nb, output bit got);
    n   = 0;
    nb  = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        n   = cyc - acc_cyc;
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_op(input string nm, input int exp_lat, input int exp_busy);
    int   n, nb;
    bit   got;
    vec_t e;
    wait_done(n, nb, got);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty when checking", nm);
      return;
    end
    e = sb.pop_front();
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no done within 200 cycles, want latency %0d", nm, exp_lat);
      return;
    end
    chk({nm, " quo"}, 64'(result[31:0]), 64'(e.q));
    chk({nm, " rem"}, 64'(result[63:32]), 64'(e.r));
    chk({nm, " dz"}, 64'(div_by_zero), 64'(e.dz));
    chk({nm, " latency"}, 64'(n), 64'(exp_lat));
    if (exp_busy >= 0) chk({nm, " busy_cycles"}, 64'(nb), 64'(exp_busy));
    @(negedge clk);
    chk({nm, " done_pulse"}, 64'(done), 64'd0);
    chk({nm, " held"}, result, {e.r, e.q});
  endtask

  initial begin
    vec_t        tbl[13];
    vec_t        e;
    logic [31:0] ra, rb;
    int          extra;

    tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    tbl[2]  = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
    tbl[3]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
    tbl[4]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tbl[5]  = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    tbl[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[7]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
    tbl[8]  = '{32'd7,          32'h8000_0000,  32'd0,          32'd7,          1'b0};
    tbl[9]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    tbl[10] = '{32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1};
    tbl[11] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd1,          32'd0,          1'b0};
    tbl[12] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};

    $display("info: DIV result slice index %0d", ALU_DIV_SLICE);

    // Reset state: clocks run while clr_n is held low.
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dz", 64'(div_by_zero), 64'd0);
    chk("reset result", result, 64'd0);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].a, tbl[i].b);
      sb.push_back(tbl[i]);
      finish_op($sformatf("vec%0d", i), tbl[i].dz ? 1 : 34, tbl[i].dz ? 0 : 33);
    end

    // Random operands, including small and zero divisors.
    for (int k = 0; k < 16; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 0) rb = 32'($urandom_range(0, 16)) - 32'd8;
      if (k % 5 == 1) ra = 32'($urandom_range(0, 1000));
      e = model(ra, rb);
      issue(ra, rb);
      sb.push_back(e);
      finish_op($sformatf("rnd%0d", k), e.dz ? 1 : 34, e.dz ? 0 : 33);
    end

    // Start while running is dropped: no restart, no second completion.
    issue(32'd1000, 32'd10);
    sb.push_back(model(32'd1000, 32'd10));
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd7;
    divisor  = 32'd7;
    @(negedge clk);
    start = 1'b0;
    finish_op("ignore_start", 34, -1);
    extra = 0;
    repeat (40) @(negedge clk) if (done) extra++;
    chk("ignore_start no_second_done", 64'(extra), 64'd0);

    // Asynchronous clear mid-operation, after a divide-by-zero left dz set.
    issue(32'd5, 32'd0);
    sb.push_back(model(32'd5, 32'd0));
    finish_op("dz_before_clr", 1, 0);
    issue(32'd1000, 32'd10);
    repeat (11) @(negedge clk);
    chk("clr busy_before", 64'(busy), 64'd1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("clr busy", 64'(busy), 64'd0);
    chk("clr done", 64'(done), 64'd0);
    chk("clr dz", 64'(div_by_zero), 64'd0);
    chk("clr result", result, 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("clr stays_idle", 64'(busy), 64'd0);
    issue(32'd9, 32'd2);
    sb.push_back('{32'd9, 32'd2, 32'd4, 32'd1, 1'b0});
    finish_op("after_clr", 34, 33);

    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
